// File: rtl/argmax_pkg.sv
// Shared types and helpers for the argmax classifier and any later top-k variants.
package argmax_pkg;

    localparam int default_num_classes = 10;

    typedef enum logic {
        COLLECT = 1'b0,
        RESULT  = 1'b1
    } state_t;

    function automatic int idx_width(input int n);
        int w;
        w = $clog2(n);
        if (w < 1) begin
            w = 1;
        end else begin
            w = w;
        end
        return w;
    endfunction

endpackage

// File: rtl/argmax_update.sv
// Combinational compare/select step of a running signed maximum; ties keep the older (lower) index.
module argmax_update
    import argmax_pkg::*;
#(
    parameter int resolution = 8,
    parameter int idxw       = 4
) (
    input  logic signed [resolution-1:0] cur_max,
    input  logic        [idxw-1:0]       cur_idx,
    input  logic signed [resolution-1:0] cand_score,
    input  logic        [idxw-1:0]       cand_idx,
    input  logic                         first,
    output logic signed [resolution-1:0] next_max,
    output logic        [idxw-1:0]       next_idx
);

    // Select the candidate when it opens a frame or strictly beats the current maximum.
    always_comb begin
        next_max = cur_max;
        next_idx = cur_idx;
        if (first || (cand_score > cur_max)) begin
            next_max = cand_score;
            next_idx = cand_idx;
        end else begin
            next_max = cur_max;
            next_idx = cur_idx;
        end
    end

endmodule

// File: rtl/argmax_classifier.sv
// Frame-based argmax over signed neuron scores with a registered result handshake.
// Optional per-frame score store enabled by defining ARGMAX_SCORE_STORE_EN.
module argmax_classifier
    import argmax_pkg::*;
#(
    parameter int num_classes = default_num_classes,
    parameter int resolution  = 8
) (
    input  logic                                  clk,
    input  logic                                  reset,
    input  logic                                  flush,
    input  logic                                  in_valid,
    output logic                                  in_ready,
    input  logic [resolution-1:0]                 in_data,
    input  logic                                  in_last,
    output logic                                  out_valid,
    input  logic                                  out_ready,
    output logic [idx_width(num_classes)-1:0]     class_idx,
    output logic [resolution-1:0]                 max_score,
    output logic                                  frame_err
`ifdef ARGMAX_SCORE_STORE_EN
    ,
    input  logic [idx_width(num_classes)-1:0]     rd_addr,
    output logic [resolution-1:0]                 rd_data
`endif
);

    localparam int IDXW = idx_width(num_classes);

    state_t                       state_r, state_s;
    logic        [IDXW-1:0]       count_r, count_s;
    logic signed [resolution-1:0] run_max_r, run_max_s;
    logic        [IDXW-1:0]       run_idx_r, run_idx_s;
    logic        [IDXW-1:0]       class_idx_r, class_idx_s;
    logic        [resolution-1:0] max_score_r, max_score_s;
    logic                         out_valid_r, out_valid_s;
    logic                         frame_err_r, frame_err_s;

    logic                         accept_s;
    logic                         at_last_slot_s;
    logic signed [resolution-1:0] upd_max_s;
    logic        [IDXW-1:0]       upd_idx_s;

    assign in_ready       = (state_r == COLLECT);
    assign accept_s       = in_valid & in_ready;
    assign at_last_slot_s = (count_r == IDXW'(num_classes - 1));

    assign out_valid = out_valid_r;
    assign class_idx = class_idx_r;
    assign max_score = max_score_r;
    assign frame_err = frame_err_r;

    argmax_update #(
        .resolution (resolution),
        .idxw       (IDXW)
    ) u_update (
        .cur_max    (run_max_r),
        .cur_idx    (run_idx_r),
        .cand_score (in_data),
        .cand_idx   (count_r),
        .first      (count_r == IDXW'(0)),
        .next_max   (upd_max_s),
        .next_idx   (upd_idx_s)
    );

    // Next-state and result decode; flush overrides any accept or transfer in the same cycle.
    always_comb begin
        state_s     = state_r;
        count_s     = count_r;
        run_max_s   = run_max_r;
        run_idx_s   = run_idx_r;
        class_idx_s = class_idx_r;
        max_score_s = max_score_r;
        out_valid_s = out_valid_r;
        frame_err_s = 1'b0;
        if (flush) begin
            state_s     = COLLECT;
            count_s     = IDXW'(0);
            out_valid_s = 1'b0;
        end else begin
            case (state_r)
                COLLECT: begin
                    if (accept_s) begin
                        if (in_last != at_last_slot_s) begin
                            count_s     = IDXW'(0);
                            frame_err_s = 1'b1;
                        end else if (in_last) begin
                            state_s     = RESULT;
                            count_s     = IDXW'(0);
                            out_valid_s = 1'b1;
                            class_idx_s = upd_idx_s;
                            max_score_s = upd_max_s;
                        end else begin
                            count_s   = count_r + IDXW'(1);
                            run_max_s = upd_max_s;
                            run_idx_s = upd_idx_s;
                        end
                    end else begin
                        state_s = COLLECT;
                    end
                end
                RESULT: begin
                    if (out_ready) begin
                        state_s     = COLLECT;
                        count_s     = IDXW'(0);
                        out_valid_s = 1'b0;
                    end else begin
                        state_s = RESULT;
                    end
                end
                default: begin
                    state_s     = COLLECT;
                    count_s     = IDXW'(0);
                    out_valid_s = 1'b0;
                end
            endcase
        end
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r     <= COLLECT;
            count_r     <= IDXW'(0);
            run_max_r   <= '0;
            run_idx_r   <= IDXW'(0);
            class_idx_r <= IDXW'(0);
            max_score_r <= '0;
            out_valid_r <= 1'b0;
            frame_err_r <= 1'b0;
        end else begin
            state_r     <= state_s;
            count_r     <= count_s;
            run_max_r   <= run_max_s;
            run_idx_r   <= run_idx_s;
            class_idx_r <= class_idx_s;
            max_score_r <= max_score_s;
            out_valid_r <= out_valid_s;
            frame_err_r <= frame_err_s;
        end
    end

`ifdef ARGMAX_SCORE_STORE_EN
    logic [resolution-1:0] store_r [num_classes];

    // Score store: written at the accept slot, cleared only by reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < num_classes; i++) begin
                store_r[i] <= '0;
            end
        end else if (accept_s && !flush) begin
            store_r[count_r] <= in_data;
        end else begin
            store_r <= store_r;
        end
    end

    // Combinational read port; addresses beyond the frame length read as zero.
    always_comb begin
        rd_data = '0;
        if (int'(rd_addr) < num_classes) begin
            rd_data = store_r[rd_addr];
        end else begin
            rd_data = '0;
        end
    end
`endif

endmodule
